sn76489_bus_controller: RTL and testbench

Host-side register interface for the PSG. Accepts the SN76489 byte-serial write protocol (latch/data and data bytes) over a valid/ready handshake and maintains the control register file: 4 attenuation registers, 3 tone-frequency registers and 1 noise-control register. Its outputs drive the tone and noise generators and the mixer directly, and replace the hardwired control values.

---
 rtl/sn76489_bus_controller_if.sv | 9 +
 rtl/sn76489_bus_controller.sv | 114 +++++++++++
 tb/tb_sn76489_bus_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sn76489_bus_controller_if.sv
// Host write bus for the SN76489 register controller: valid/ready byte handshake.
interface sn76489_bus_controller_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/sn76489_bus_controller.sv
// SN76489 byte-serial write decoder and control register file.
// Optional READY/BUSY write-recovery model is built when SN76489_READY_EN is defined.
module sn76489_bus_controller #(
    parameter int NUM_TONES                = 3,
    parameter int ATTENUATION_CONTROL_BITS = 4,
    parameter int TONE_FREQUENCY_BITS      = 10,
    parameter int NOISE_CONTROL_BITS       = 3,
    parameter int BUSY_CYCLES              = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    sn76489_bus_controller_if.slave                 bus,
    output logic [4*ATTENUATION_CONTROL_BITS-1:0]   attn_out,
    output logic [NUM_TONES*TONE_FREQUENCY_BITS-1:0] tone_freq_out,
    output logic [NOISE_CONTROL_BITS-1:0]           noise_ctrl_out,
    output logic                                    noise_reset,
    output logic [2:0]                              latched_reg
);
    localparam int ACB = ATTENUATION_CONTROL_BITS;
    localparam int TFB = TONE_FREQUENCY_BITS;
    localparam int NCB = NOISE_CONTROL_BITS;

    if (BUSY_CYCLES < 1) begin : g_bad_busy
        $error("BUSY_CYCLES must be >= 1");
    end

    logic [ACB-1:0] r_attn [4];
    logic [TFB-1:0] r_tone [NUM_TONES];
    logic [NCB-1:0] r_noise;
    logic           r_noise_reset;
    logic [2:0]     r_latched;

    logic           w_ready;
    logic           w_accept;
    logic           w_is_latch;
    logic [1:0]     w_ch;
    logic           w_type;

    assign w_accept   = bus.wr_valid && w_ready;
    assign w_is_latch = bus.wr_data[7];
    // Data bytes inherit their target from the most recent latch byte.
    assign w_ch       = w_is_latch ? bus.wr_data[6:5] : r_latched[2:1];
    assign w_type     = w_is_latch ? bus.wr_data[4]   : r_latched[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) r_attn[i] <= '1;
            for (int unsigned i = 0; i < NUM_TONES; i++) r_tone[i] <= '0;
            r_noise       <= '0;
            r_noise_reset <= 1'b0;
            r_latched     <= '0;
        end else begin
            r_noise_reset <= 1'b0;
            if (w_accept) begin
                if (w_is_latch) r_latched <= bus.wr_data[6:4];
                if (w_type) begin
                    r_attn[w_ch] <= ACB'(bus.wr_data[3:0]);
                end else if (w_ch == 2'd3) begin
                    r_noise       <= NCB'(bus.wr_data[2:0]);
                    r_noise_reset <= 1'b1;
                end else if (32'(w_ch) < NUM_TONES) begin
                    if (w_is_latch) r_tone[w_ch][3:0]     <= bus.wr_data[3:0];
                    else            r_tone[w_ch][TFB-1:4] <= (TFB-4)'(bus.wr_data[5:0]);
                end
            end
        end
    end

    always_comb begin
        attn_out      = '0;
        tone_freq_out = '0;
        for (int unsigned c = 0; c < 4; c++) attn_out[c*ACB +: ACB] = r_attn[c];
        for (int unsigned c = 0; c < NUM_TONES; c++) tone_freq_out[c*TFB +: TFB] = r_tone[c];
    end

    assign noise_ctrl_out = r_noise;
    assign noise_reset    = r_noise_reset;
    assign latched_reg    = r_latched;

`ifdef SN76489_READY_EN
    localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;
    state_t        r_state, w_state_next;
    logic [CW-1:0] r_busy_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_busy_cnt <= (r_state == S_BUSY) ? r_busy_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b1;
        case (r_state)
            S_IDLE: if (bus.wr_valid) w_state_next = S_BUSY;
            S_BUSY: begin
                w_ready = 1'b0;
                if (r_busy_cnt == CW'(BUSY_CYCLES - 1)) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end
`else
    assign w_ready = 1'b1;
`endif

    assign bus.wr_ready = w_ready;
endmodule

// File: tb/tb_sn76489_bus_controller.sv
// Self-checking bench for sn76489_bus_controller against a spec-level register model.
module tb_sn76489_bus_controller;
    localparam int BUSY = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] attn_out;
    logic [29:0] tone_freq_out;
    logic [2:0]  noise_ctrl_out;
    logic        noise_reset;
    logic [2:0]  latched_reg;

    always #5 clk = ~clk;

    sn76489_bus_controller_if bus();

    sn76489_bus_controller #(
        .NUM_TONES(3), .ATTENUATION_CONTROL_BITS(4), .TONE_FREQUENCY_BITS(10),
        .NOISE_CONTROL_BITS(3), .BUSY_CYCLES(BUSY)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus),
        .attn_out(attn_out), .tone_freq_out(tone_freq_out),
        .noise_ctrl_out(noise_ctrl_out), .noise_reset(noise_reset),
        .latched_reg(latched_reg)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register contents, latched target and accept history.
    logic [3:0] m_attn [4];
    logic [9:0] m_tone [3];
    logic [2:0] m_noise;
    logic       m_nr;
    logic [2:0] m_lat;
    int         cyc;      // index of the next rising edge
    int         last_acc; // edge index of the last accepted byte

    function automatic bit m_ready();
`ifdef SN76489_READY_EN
        return (cyc - last_acc) >= BUSY + 1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] exp_attn();
        return {m_attn[3], m_attn[2], m_attn[1], m_attn[0]};
    endfunction

    function automatic logic [29:0] exp_tone();
        return {m_tone[2], m_tone[1], m_tone[0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_attn[i] = 4'hF;
        for (int i = 0; i < 3; i++) m_tone[i] = 10'h000;
        m_noise  = 3'd0;
        m_nr     = 1'b0;
        m_lat    = 3'd0;
        last_acc = -1000000;
    endfunction

    function automatic void model_write(input logic [7:0] d);
        int   ch;
        logic typ;
        if (d[7]) m_lat = d[6:4];
        ch  = d[7] ? int'(d[6:5]) : int'(m_lat[2:1]);
        typ = d[7] ? d[4] : m_lat[0];
        if (typ) m_attn[ch] = d[3:0];
        else if (ch == 3) begin
            m_noise = d[2:0];
            m_nr    = 1'b1;
        end else if (d[7]) m_tone[ch] = (m_tone[ch] & 10'h3F0) | 10'(d[3:0]);
        else               m_tone[ch] = (m_tone[ch] & 10'h00F) | (10'(d[5:0]) << 4);
    endfunction

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] d);
        bit acc;
        @(negedge clk);
        reset        = 1'b0;
        bus.wr_valid = v;
        bus.wr_data  = d;
        acc = v && m_ready();
        @(posedge clk);
        #1;
        m_nr = 1'b0;
        if (acc) begin
            last_acc = cyc;
            model_write(d);
        end
        cyc++;
    endtask

    task automatic write_byte(input logic [7:0] d);
        for (int i = 0; i < BUSY + 2 && !m_ready(); i++) step(1'b0, 8'h00);
        step(1'b1, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h9A;
        @(posedge clk);
        #1;
        model_reset();
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (attn_out !== 16'hFFFF) begin bad++; $display("FAIL reset_attn got=%h exp=%h", attn_out, 16'hFFFF); end
        total++; if (tone_freq_out !== 30'd0) begin bad++; $display("FAIL reset_tone got=%h exp=0", tone_freq_out); end
        total++; if (noise_ctrl_out !== 3'd0) begin bad++; $display("FAIL reset_noise got=%h exp=0", noise_ctrl_out); end
        total++; if (noise_reset !== 1'b0) begin bad++; $display("FAIL reset_nr got=%b exp=0", noise_reset); end
        total++; if (latched_reg !== 3'd0) begin bad++; $display("FAIL reset_latched got=%h exp=0", latched_reg); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.wr_ready); end
    endtask

    task automatic test_data_after_reset();
        write_byte(8'h2A);
        total++; if (tone_freq_out[9:0] !== 10'h2A0) begin bad++; $display("FAIL data_after_reset_tone got=%h exp=%h", tone_freq_out[9:0], 10'h2A0); end
        total++; if (latched_reg !== 3'd0) begin bad++; $display("FAIL data_after_reset_lat got=%h exp=0", latched_reg); end
    endtask

    task automatic test_tone();
        write_byte(8'h8E);
        total++; if (tone_freq_out[3:0] !== 4'hE) begin bad++; $display("FAIL tone_latch_low got=%h exp=e", tone_freq_out[3:0]); end
        total++; if (tone_freq_out !== exp_tone()) begin bad++; $display("FAIL tone_latch got=%h exp=%h", tone_freq_out, exp_tone()); end
        write_byte(8'h0F);
        total++; if (tone_freq_out[9:0] !== 10'h0FE) begin bad++; $display("FAIL tone_data got=%h exp=%h", tone_freq_out[9:0], 10'h0FE); end
        write_byte(8'h8A);
        total++; if (tone_freq_out[9:0] !== 10'h0FA) begin bad++; $display("FAIL tone_relatch got=%h exp=%h", tone_freq_out[9:0], 10'h0FA); end
        total++; if (tone_freq_out !== exp_tone()) begin bad++; $display("FAIL tone_all got=%h exp=%h", tone_freq_out, exp_tone()); end
    endtask

    task automatic test_attn();
        logic [29:0] tone_before;
        tone_before = tone_freq_out;
        write_byte(8'hD5);
        total++; if (attn_out[11:8] !== 4'h5) begin bad++; $display("FAIL attn_ch2 got=%h exp=5", attn_out[11:8]); end
        total++; if (attn_out !== exp_attn()) begin bad++; $display("FAIL attn_all got=%h exp=%h", attn_out, exp_attn()); end
        write_byte(8'h90);
        write_byte(8'h3C);
        total++; if (attn_out[3:0] !== 4'hC) begin bad++; $display("FAIL attn_ch0_data got=%h exp=c", attn_out[3:0]); end
        total++; if (attn_out !== exp_attn()) begin bad++; $display("FAIL attn_all2 got=%h exp=%h", attn_out, exp_attn()); end
        total++; if (tone_freq_out !== tone_before) begin bad++; $display("FAIL attn_tone_untouched got=%h exp=%h", tone_freq_out, tone_before); end
    endtask

    task automatic test_noise();
        write_byte(8'hE6);
        total++; if (noise_ctrl_out !== 3'b110) begin bad++; $display("FAIL noise_latch got=%b exp=110", noise_ctrl_out); end
        total++; if (noise_reset !== 1'b1) begin bad++; $display("FAIL noise_pulse1 got=%b exp=1", noise_reset); end
        step(1'b0, 8'h00);
        total++; if (noise_reset !== 1'b0) begin bad++; $display("FAIL noise_pulse1_end got=%b exp=0", noise_reset); end
        write_byte(8'h03);
        total++; if (noise_ctrl_out !== 3'b011) begin bad++; $display("FAIL noise_data got=%b exp=011", noise_ctrl_out); end
        total++; if (noise_reset !== 1'b1) begin bad++; $display("FAIL noise_pulse2 got=%b exp=1", noise_reset); end
        step(1'b0, 8'h00);
        total++; if (noise_reset !== 1'b0) begin bad++; $display("FAIL noise_pulse2_end got=%b exp=0", noise_reset); end
    endtask

`ifndef SN76489_READY_EN
    task automatic test_back_to_back();
        logic [7:0] seq [4];
        seq = '{8'hE1, 8'h02, 8'h45, 8'h07};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i]);
            total++; if (noise_reset !== 1'b1) begin bad++; $display("FAIL b2b_pulse[%0d] got=%b exp=1", i, noise_reset); end
            total++; if (noise_ctrl_out !== m_noise) begin bad++; $display("FAIL b2b_noise[%0d] got=%b exp=%b", i, noise_ctrl_out, m_noise); end
            total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, bus.wr_ready); end
        end
        step(1'b0, 8'h00);
        total++; if (noise_reset !== 1'b0) begin bad++; $display("FAIL b2b_pulse_end got=%b exp=0", noise_reset); end
    endtask
`else
    task automatic test_ready_timing();
        do_reset();
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 8'h80 | 8'(i & 15));
            total++; if (bus.wr_ready !== m_ready()) begin bad++; $display("FAIL ready_hold[%0d] got=%b exp=%b", i, bus.wr_ready, m_ready()); end
            total++; if (tone_freq_out !== exp_tone()) begin bad++; $display("FAIL ready_tone[%0d] got=%h exp=%h", i, tone_freq_out, exp_tone()); end
        end
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 8'hC0 | 8'(i));
        do_reset();
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", bus.wr_ready); end
        total++; if (attn_out !== 16'hFFFF) begin bad++; $display("FAIL ready_reset_attn got=%h exp=ffff", attn_out); end
        step(1'b1, 8'hC7);
        total++; if (attn_out !== exp_attn()) begin bad++; $display("FAIL ready_post_reset_accept got=%h exp=%h", attn_out, exp_attn()); end
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL ready_post_reset_busy got=%b exp=0", bus.wr_ready); end
    endtask
`endif

    task automatic test_random();
        logic       v;
        logic [7:0] d;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 9) < 7);
            d = 8'($urandom);
            step(v, d);
            total++; if (attn_out !== exp_attn()) begin bad++; $display("FAIL rnd_attn[%0d] got=%h exp=%h", i, attn_out, exp_attn()); end
            total++; if (tone_freq_out !== exp_tone()) begin bad++; $display("FAIL rnd_tone[%0d] got=%h exp=%h", i, tone_freq_out, exp_tone()); end
            total++; if (noise_ctrl_out !== m_noise) begin bad++; $display("FAIL rnd_noise[%0d] got=%h exp=%h", i, noise_ctrl_out, m_noise); end
            total++; if (noise_reset !== m_nr) begin bad++; $display("FAIL rnd_nr[%0d] got=%b exp=%b", i, noise_reset, m_nr); end
            total++; if (latched_reg !== m_lat) begin bad++; $display("FAIL rnd_lat[%0d] got=%h exp=%h", i, latched_reg, m_lat); end
            total++; if (bus.wr_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, bus.wr_ready, m_ready()); end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        cyc          = 0;
        model_reset();
        test_reset();
        test_data_after_reset();
        test_tone();
        test_attn();
        test_noise();
`ifndef SN76489_READY_EN
        test_back_to_back();
`else
        test_ready_timing();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
